// File: rtl/task_tcb.sv
// task_tcb: task control block for one task of the FPGA-side scheduler.
//
// Holds the lifecycle state, base and effective priority, the execution-hit
// budget, the dispatch flag and an aging counter. Commands arrive on a shared
// 16-bit op bus. While the task is eligible it presents
// {TASK_ID, eff_prio} to the priority sorter.
//
// Ports:
//   CLK         sole clock, rising edge
//   RST         synchronous active-high reset, overrides any op
//   op_valid    qualifies in_op
//   in_op       [15:12] reserved, [11:8] target, [7:4] opcode, [3:0] operand
//   out_sorter  {TASK_ID, eff_prio} when eligible, otherwise 0
//   state       00 Ready, 01 Suspended, 10 Wait, 11 Terminated
//   running     task is dispatched
//   exe_hit     remaining execution-hit budget
//   exec_ack    one-cycle pulse after an accepted Execute
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_READY     | may be dispatched; eligible when idle with budget left
// ST_SUSPENDED | parked by a Suspend op
// ST_WAIT      | parked by a Wait op
// ST_TERMINATED| absorbing; every op ignored until RST
//
// TASK_ID must not be 4'hF, which is the broadcast target.

module task_tcb #(
    parameter logic [3:0] TASK_ID    = 4'h4,
    parameter int         PRIO_W     = 4,
    parameter int         HIT_W      = 8,
    parameter int         HIT_INIT   = 128,
    parameter int         AGE_PERIOD = 10000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  op_valid,
    input  logic [15:0]           in_op,
    output logic [4+PRIO_W-1:0]   out_sorter,
    output logic [1:0]            state,
    output logic                  running,
    output logic [HIT_W-1:0]      exe_hit,
    output logic                  exec_ack
);

    typedef enum logic [1:0] {
        ST_READY      = 2'b00,
        ST_SUSPENDED  = 2'b01,
        ST_WAIT       = 2'b10,
        ST_TERMINATED = 2'b11
    } state_t;

    localparam logic [3:0]  OP_READY   = 4'b0001;
    localparam logic [3:0]  OP_SUSPEND = 4'b0010;
    localparam logic [3:0]  OP_WAIT    = 4'b0011;
    localparam logic [3:0]  OP_KILL    = 4'b0100;
    localparam logic [3:0]  OP_SETPRI  = 4'b0101;
    localparam logic [3:0]  OP_SETHIT  = 4'b0110;
    localparam logic [3:0]  OP_EXEC    = 4'b0111;
    localparam logic [3:0]  OP_FINISH  = 4'b1111;
    localparam logic [3:0]  BCAST_ID   = 4'hF;
    localparam logic [31:0] AGE_LAST   = 32'(AGE_PERIOD - 1);

    state_t              state_q, state_d;
    logic                running_q, running_d;
    logic [HIT_W-1:0]    hit_q, hit_d;
    logic [PRIO_W-1:0]   base_q, base_d;
    logic [PRIO_W-1:0]   eff_q, eff_d;
    logic [31:0]         age_q, age_d;
    logic                ack_q, ack_d;

    logic [3:0]          target;
    logic [3:0]          opcode;
    logic [3:0]          operand;
    logic                is_state_op;
    logic                op_hit;
    logic                eligible;
    logic                op_accepted;
    logic                unused_op_bits;

    assign target   = in_op[11:8];
    assign opcode   = in_op[7:4];
    assign operand  = in_op[3:0];

    // Reserved bits and operand bits above PRIO_W carry no meaning here.
    assign unused_op_bits = ^in_op;

    // Only the four state-setting opcodes honour the broadcast target.
    assign is_state_op = (opcode >= OP_READY) && (opcode <= OP_KILL);
    assign op_hit = op_valid &&
                    ((target == TASK_ID) || ((target == BCAST_ID) && is_state_op));

    assign eligible = (state_q == ST_READY) && !running_q && (hit_q != '0);

    always_comb begin
        state_d     = state_q;
        running_d   = running_q;
        hit_d       = hit_q;
        base_d      = base_q;
        eff_d       = eff_q;
        age_d       = age_q;
        ack_d       = 1'b0;
        op_accepted = 1'b0;

        if (op_hit && (state_q != ST_TERMINATED)) begin
            case (opcode)
                OP_READY, OP_SUSPEND, OP_WAIT, OP_KILL: begin
                    case (opcode)
                        OP_READY:   state_d = ST_READY;
                        OP_SUSPEND: state_d = ST_SUSPENDED;
                        OP_WAIT:    state_d = ST_WAIT;
                        default:    state_d = ST_TERMINATED;
                    endcase
                    // Re-asserting the current state is not a state change.
                    if (state_d != state_q) begin
                        age_d = '0;
                    end
                    running_d   = 1'b0;
                    op_accepted = 1'b1;
                end
                OP_SETPRI: begin
                    base_d      = operand[PRIO_W-1:0];
                    eff_d       = operand[PRIO_W-1:0];
                    age_d       = '0;
                    op_accepted = 1'b1;
                end
                OP_SETHIT: begin
                    hit_d       = HIT_W'(operand);
                    op_accepted = 1'b1;
                end
                OP_EXEC: begin
                    if ((state_q == ST_READY) && !running_q && (hit_q != '0)) begin
                        running_d   = 1'b1;
                        ack_d       = 1'b1;
                        op_accepted = 1'b1;
                    end
                end
                OP_FINISH: begin
                    if (running_q && (state_q == ST_READY)) begin
                        running_d   = 1'b0;
                        // Budget may have been zeroed while running; never wrap.
                        if (hit_q != '0) begin
                            hit_d = hit_q - 1'b1;
                        end
                        eff_d       = base_q;
                        age_d       = '0;
                        op_accepted = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end

        // An accepted op swallows the aging tick of the same cycle.
        if (!op_accepted && eligible) begin
            if (age_q == AGE_LAST) begin
                age_d = '0;
                if (eff_q != '1) begin
                    eff_d = eff_q + 1'b1;
                end
            end else begin
                age_d = age_q + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_READY;
            running_q <= 1'b0;
            hit_q     <= HIT_W'(HIT_INIT);
            base_q    <= '0;
            eff_q     <= '0;
            age_q     <= '0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            hit_q     <= hit_d;
            base_q    <= base_d;
            eff_q     <= eff_d;
            age_q     <= age_d;
            ack_q     <= ack_d;
        end
    end

    assign out_sorter = eligible ? {TASK_ID, eff_q} : '0;
    assign state      = state_q;
    assign running    = running_q;
    assign exe_hit    = hit_q;
    assign exec_ack   = ack_q;

endmodule

// File: tb/tb_task_tcb.sv
// Testbench for task_tcb: directed scenarios followed by random op traffic.
// A driver issues one op per cycle and pushes the reference model's expected
// post-edge outputs into a queue; a monitor pops and compares after each edge.

module tb_task_tcb;

    localparam int AP = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        op_valid;
    logic [15:0] in_op;
    logic [7:0]  out_sorter;
    logic [1:0]  state;
    logic        running;
    logic [7:0]  exe_hit;
    logic        exec_ack;

    task_tcb #(
        .TASK_ID   (4'h4),
        .PRIO_W    (4),
        .HIT_W     (8),
        .HIT_INIT  (128),
        .AGE_PERIOD(AP)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .op_valid  (op_valid),
        .in_op     (in_op),
        .out_sorter(out_sorter),
        .state     (state),
        .running   (running),
        .exe_hit   (exe_hit),
        .exec_ack  (exec_ack)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] sorter;
        logic [1:0] st;
        logic       run;
        logic [7:0] hit;
        logic       ack;
        int         idx;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   n_issued = 0;

    // Reference model state, plain integers.
    int m_state;   // 0 Ready, 1 Suspended, 2 Wait, 3 Terminated
    int m_run;
    int m_hit;
    int m_base;
    int m_eff;
    int m_age;
    int m_ack;

    task automatic model_step(input logic rst, input logic vld, input logic [15:0] op);
        int  tgt, opc, opd, new_state;
        bit  addressed, accepted, was_eligible;
        tgt = int'(op[11:8]);
        opc = int'(op[7:4]);
        opd = int'(op[3:0]);
        if (rst) begin
            m_state = 0; m_run = 0; m_hit = 128; m_base = 0;
            m_eff = 0; m_age = 0; m_ack = 0;
            return;
        end
        m_ack = 0;
        accepted = 0;
        was_eligible = (m_state == 0) && (m_run == 0) && (m_hit != 0);
        addressed = vld && ((tgt == 4) || (tgt == 15 && opc >= 1 && opc <= 4));
        if (addressed && m_state != 3) begin
            if (opc >= 1 && opc <= 4) begin
                new_state = opc - 1;
                if (new_state != m_state) m_age = 0;
                m_state = new_state;
                m_run = 0;
                accepted = 1;
            end else if (opc == 5) begin
                m_base = opd; m_eff = opd; m_age = 0;
                accepted = 1;
            end else if (opc == 6) begin
                m_hit = opd;
                accepted = 1;
            end else if (opc == 7) begin
                if (m_state == 0 && m_run == 0 && m_hit > 0) begin
                    m_run = 1; m_ack = 1; accepted = 1;
                end
            end else if (opc == 15) begin
                if (m_run == 1 && m_state == 0) begin
                    m_run = 0;
                    if (m_hit > 0) m_hit = m_hit - 1;
                    m_eff = m_base;
                    m_age = 0;
                    accepted = 1;
                end
            end
        end
        if (!accepted && was_eligible) begin
            if (m_age == AP - 1) begin
                m_age = 0;
                if (m_eff < 15) m_eff = m_eff + 1;
            end else begin
                m_age = m_age + 1;
            end
        end
    endtask

    function automatic exp_t model_outputs(input int idx);
        exp_t e;
        bit   elig;
        elig     = (m_state == 0) && (m_run == 0) && (m_hit != 0);
        e.sorter = elig ? 8'(8'h40 + m_eff) : 8'h00;
        e.st     = 2'(m_state);
        e.run    = 1'(m_run);
        e.hit    = 8'(m_hit);
        e.ack    = 1'(m_ack);
        e.idx    = idx;
        return e;
    endfunction

    task automatic drive(input logic rst, input logic vld, input logic [15:0] op);
        @(negedge CLK);
        RST      = rst;
        op_valid = vld;
        in_op    = op;
        model_step(rst, vld, op);
        sb_q.push_back(model_outputs(n_issued));
        n_issued++;
    endtask

    task automatic check_field(input string name, input int idx,
                               input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s op#%0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    // Monitor: every edge that follows an issued op has one expected entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_field("out_sorter", e.idx, out_sorter, e.sorter);
                check_field("state",      e.idx, {6'b0, state},    {6'b0, e.st});
                check_field("running",    e.idx, {7'b0, running},  {7'b0, e.run});
                check_field("exe_hit",    e.idx, exe_hit,          e.hit);
                check_field("exec_ack",   e.idx, {7'b0, exec_ack}, {7'b0, e.ack});
            end
        end
    end

    function automatic logic [15:0] random_op();
        logic [3:0] tgt, opc, opd, rsv;
        int         r;
        int         opc_tab[16] = '{1, 2, 3, 5, 6, 7, 7, 7, 15, 15, 15, 0, 0, 0, 4, 9};
        r = $urandom_range(0, 9);
        if (r < 6)      tgt = 4'h4;
        else if (r < 8) tgt = 4'hF;
        else            tgt = 4'($urandom_range(0, 15));
        opc = 4'(opc_tab[$urandom_range(0, 15)]);
        // Keep Kill rare so most of the run is spent outside Terminated.
        if (opc == 4'h4 && $urandom_range(0, 3) != 0) opc = 4'h0;
        opd = 4'($urandom_range(0, 15));
        rsv = 4'($urandom_range(0, 15));
        return {rsv, tgt, opc, opd};
    endfunction

    initial begin
        RST      = 1'b1;
        op_valid = 1'b0;
        in_op    = 16'h0000;

        // Reset state
        drive(1, 0, 16'h0000);
        drive(0, 0, 16'h0000);

        // Set priority, execute, finish
        drive(0, 1, 16'h0453);
        drive(0, 1, 16'h0470);
        drive(0, 0, 16'h0000);
        drive(0, 1, 16'h04F0);

        // Aging and saturation, then Finish restores base priority
        drive(0, 1, 16'h045E);
        repeat (12) drive(0, 0, 16'h0000);
        drive(0, 1, 16'h0470);
        drive(0, 1, 16'h04F0);
        drive(0, 0, 16'h0000);

        // Broadcast Kill, ops ignored in Terminated, reset recovers
        drive(0, 1, 16'h0F40);
        drive(0, 1, 16'h0410);
        drive(0, 1, 16'h0465);
        drive(0, 1, 16'h0470);
        drive(1, 0, 16'h0000);

        // Budget exhaustion
        drive(0, 1, 16'h0461);
        drive(0, 1, 16'h0470);
        drive(0, 1, 16'h04F0);
        drive(0, 1, 16'h0470);
        drive(0, 0, 16'h0000);

        // Filtering and interrupt
        drive(1, 0, 16'h0000);
        drive(0, 1, 16'h0370);
        drive(0, 0, 16'h0470);
        drive(0, 1, 16'h0F70);
        drive(0, 1, 16'h0470);
        drive(0, 1, 16'h0420);
        drive(0, 1, 16'h0410);

        // Zero budget while running: one Finish, no wrap
        drive(0, 1, 16'h0470);
        drive(0, 1, 16'h0460);
        drive(0, 1, 16'h04F0);
        drive(0, 1, 16'h04F0);
        drive(0, 1, 16'h0465);

        // Reset overrides a same-cycle op and drops the dispatch
        drive(0, 1, 16'h0470);
        drive(1, 1, 16'h04F0);
        drive(0, 0, 16'h0000);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0)
                drive(1, 1'($urandom_range(0, 1)), random_op());
            else
                drive(0, 1'($urandom_range(0, 9) != 0), random_op());
        end

        @(negedge CLK);
        op_valid = 1'b0;
        RST      = 1'b0;
        for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(posedge CLK);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
